// File: rtl/timer_scheduler_rr.sv
// timer_scheduler_rr: one prescaled down-counter timer shared by NREQ
// requesters. An idle cycle arbitrates pending requests, loads the winner's
// tick count, runs the timer and pulses that requester's done on expiry.
// Optional build macro TIMER_SCHED_FIXPRIO_EN selects fixed priority (lowest
// index wins) instead of the default round-robin pointer.
module timer_scheduler_rr #(
    parameter int NREQ    = 4,
    parameter int CW      = 24,
    parameter int PRE_DIV = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   load,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [IW-1:0]   win_q, win_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;

    logic [IW-1:0]   pick;
    logic            found;
    int unsigned     idx;
    logic [CW-1:0]   sel_load;

`ifndef TIMER_SCHED_FIXPRIO_EN
    localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_next;

    assign win_next = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
`endif

    // Arbiter: first set req bit scanning upward from the priority base, wrapping
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef TIMER_SCHED_FIXPRIO_EN
            idx = i;
`else
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
`endif
            if (!found && req[IW'(idx)]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    end

    // Tick count of the arbitration winner
    always_comb begin
        sel_load = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) sel_load = load[i*CW +: CW];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        busy_d  = busy_q;
`ifndef TIMER_SCHED_FIXPRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (found) begin
                    win_d       = pick;
                    cnt_d       = sel_load;
                    pre_d       = '0;
                    gnt_d[pick] = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                // Abort outranks expiry so a dropped request never sees done
                if (!req[win_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
`ifndef TIMER_SCHED_FIXPRIO_EN
                    ptr_d   = win_next;
`endif
                end else if (cnt_q == '0) begin
                    state_d       = DONE;
                    gnt_d         = '0;
                    done_d[win_q] = 1'b1;
                end else if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
`ifndef TIMER_SCHED_FIXPRIO_EN
                ptr_d   = win_next;
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
`ifndef TIMER_SCHED_FIXPRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifndef TIMER_SCHED_FIXPRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_timer_scheduler_rr.sv
// Testbench for timer_scheduler_rr (NREQ=4, CW=8, PRE_DIV=4): directed
// scenarios plus randomized traffic against a deadline-based reference model.
module tb_timer_scheduler_rr;

    localparam int NREQ    = 4;
    localparam int CW      = 8;
    localparam int PRE_DIV = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*CW-1:0]   load;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;

    timer_scheduler_rr #(
        .NREQ   (NREQ),
        .CW     (CW),
        .PRE_DIV(PRE_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .load (load),
        .gnt  (gnt),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a service is a grant at cycle G with a fixed deadline
    // G + N*PRE_DIV + 1 for its done pulse, cancelled by reset or a dropped req.
    int unsigned     cyc = 0;
    bit              m_active = 0;
    bit              m_done_ph = 0;
    int unsigned     m_win = 0;
    int unsigned     m_ptr = 0;
    int unsigned     m_deadline = 0;
    logic [NREQ-1:0] e_gnt = '0;
    logic [NREQ-1:0] e_done = '0;
    logic            e_busy = 1'b0;

    function automatic int unsigned m_pick();
        int unsigned base;
        int unsigned k;
`ifdef TIMER_SCHED_FIXPRIO_EN
        base = 0;
`else
        base = m_ptr;
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (base + i) % NREQ;
            if (req[k]) return k;
        end
        return 0;
    endfunction

    function automatic void model_update();
        logic [NREQ-1:0] ng;
        logic [NREQ-1:0] nd;
        logic            nb;
        ng = '0;
        nd = '0;
        nb = 1'b0;
        if (reset) begin
            m_active  = 0;
            m_done_ph = 0;
            m_ptr     = 0;
        end else if (m_done_ph) begin
            m_done_ph = 0;
            m_ptr     = (m_win + 1) % NREQ;
        end else if (m_active) begin
            if (!req[m_win]) begin
                m_active = 0;
                m_ptr    = (m_win + 1) % NREQ;
            end else if (cyc + 1 == m_deadline) begin
                m_active  = 0;
                m_done_ph = 1;
                nd[m_win] = 1'b1;
                nb        = 1'b1;
            end else begin
                ng[m_win] = 1'b1;
                nb        = 1'b1;
            end
        end else if (req != '0) begin
            m_win      = m_pick();
            m_active   = 1;
            m_deadline = cyc + 1 + int'(load[m_win*CW +: CW]) * PRE_DIV + 1;
            ng[m_win]  = 1'b1;
            nb         = 1'b1;
        end
        e_gnt  = ng;
        e_done = nd;
        e_busy = nb;
    endfunction

    // Advance one clock; outputs are valid on return (1 time unit after the edge)
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic int unsigned onehot_idx(input logic [NREQ-1:0] v);
        for (int unsigned i = 0; i < NREQ; i++) if (v[i]) return i;
        return 99;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        load  = 32'h0101_0101;
        for (int t = 0; t < 5; t++) begin
            step();
            n_cmp++;
            if ({gnt, done, busy} !== 9'b0) begin
                n_bad++;
                $display("FAIL reset_outputs: gnt=%b done=%b busy=%b expected all 0", gnt, done, busy);
            end
        end
        reset = 1'b0;
        req   = '0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        load = '0;
        load[2*CW +: CW] = 8'd3;
        req  = 4'b0100;
        for (int t = 1; t <= 14; t++) begin
            step();
            n_cmp++;
            if (gnt !== ((t < 14) ? 4'b0100 : 4'b0000) ||
                done !== ((t == 14) ? 4'b0100 : 4'b0000)) begin
                n_bad++;
                $display("FAIL single_load3 t=%0d: gnt=%b done=%b", t, gnt, done);
            end
        end
        req = '0;
        step();
        n_cmp++;
        if (done !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after_done: done=%b busy=%b expected 0/0", done, busy);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int unsigned order[$];
        int unsigned exp_order[5];
        int unsigned g_cyc;
        int unsigned g_idx;
        logic [NREQ-1:0] prev;
`ifdef TIMER_SCHED_FIXPRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        load  = 32'h0101_0101;
        req   = 4'b1111;
        prev  = '0;
        g_cyc = 0;
        g_idx = 0;
        for (int t = 0; t < 60 && order.size() < 5; t++) begin
            step();
            if (prev == '0 && gnt != '0) begin
                g_cyc = cyc;
                g_idx = onehot_idx(gnt);
                order.push_back(g_idx);
            end
            if (done != '0) begin
                n_cmp++;
                if (done !== (4'b0001 << g_idx) || cyc - g_cyc != 5) begin
                    n_bad++;
                    $display("FAIL rr_done_latency: done=%b after %0d cycles, expected idx %0d after 5",
                             done, cyc - g_cyc, g_idx);
                end
            end
            prev = gnt;
        end
        n_cmp++;
        if (order.size() != 5) begin
            n_bad++;
            $display("FAIL rr_grant_count: got %0d grants expected 5", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            n_cmp++;
            if (order[i] != exp_order[i]) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
            end
        end
        req = '0;
        step();
        step();
        step();
    endtask

    task automatic test_zero_load();
        do_reset();
        load = 32'h0505_0500;
        req  = 4'b0001;
        step();
        n_cmp++;
        if (gnt !== 4'b0001 || done !== 4'b0000) begin
            n_bad++;
            $display("FAIL zero_load_grant: gnt=%b done=%b expected 0001/0000", gnt, done);
        end
        step();
        n_cmp++;
        if (gnt !== 4'b0000 || done !== 4'b0001 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_load_done: gnt=%b done=%b busy=%b expected 0000/0001/1", gnt, done, busy);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_abort();
        logic [NREQ-1:0] exp_g;
        do_reset();
        load = '0;
        load[1*CW +: CW] = 8'd10;
        req  = 4'b0010;
        step();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL abort_grant: gnt=%b expected 0010", gnt);
        end
        for (int t = 0; t < 6; t++) step();
        req = 4'b0000;
        step();
        n_cmp++;
        if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_release: gnt=%b done=%b busy=%b expected 0", gnt, done, busy);
        end
        for (int t = 0; t < 40; t++) begin
            step();
            n_cmp++;
            if (done !== 4'b0000) begin
                n_bad++;
                $display("FAIL abort_no_done: done=%b expected 0000", done);
            end
        end
        load = 32'h0202_0202;
        req  = 4'b1010;
`ifdef TIMER_SCHED_FIXPRIO_EN
        exp_g = 4'b0010;
`else
        exp_g = 4'b1000;
`endif
        step();
        n_cmp++;
        if (gnt !== exp_g) begin
            n_bad++;
            $display("FAIL abort_next_winner: gnt=%b expected %b", gnt, exp_g);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_reset_midrun();
        int found_t;
        do_reset();
        load = 32'h0000_0005;
        req  = 4'b0001;
        for (int t = 0; t < 5; t++) step();
        reset = 1'b1;
        step();
        n_cmp++;
        if ({gnt, done, busy} !== 9'b0) begin
            n_bad++;
            $display("FAIL midrun_reset: gnt=%b done=%b busy=%b expected 0", gnt, done, busy);
        end
        reset = 1'b0;
        load  = 32'h0000_0002;
        step();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL midrun_regrant: gnt=%b expected 0001", gnt);
        end
        found_t = -1;
        for (int t = 1; t <= 20 && found_t < 0; t++) begin
            step();
            if (done != '0) found_t = t;
        end
        n_cmp++;
        if (found_t != 9 || done !== 4'b0001) begin
            n_bad++;
            $display("FAIL midrun_done_latency: done=%b at gnt+%0d expected 0001 at gnt+9", done, found_t);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 2500; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if ($urandom_range(59) == 0) req[i] = 1'b0;
                end else begin
                    if ($urandom_range(5) == 0) req[i] = 1'b1;
                end
                load[i*CW +: CW] = 8'($urandom_range(4));
            end
            reset = ($urandom_range(299) == 0);
            step();
            n_cmp++;
            if (gnt !== e_gnt || done !== e_done || busy !== e_busy) begin
                n_bad++;
                $display("FAIL random cyc=%0d: gnt=%b done=%b busy=%b expected %b/%b/%b",
                         cyc, gnt, done, busy, e_gnt, e_done, e_busy);
            end
        end
        reset = 1'b0;
        req   = '0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        load  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_load();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
